// File: rtl/mult_sequencer.sv
// mult_sequencer: sequencing controller for a shift-add signed multiplier.
// Clears X:A, then runs WIDTH evaluate/shift steps driven by the multiplier LSB.
// Ports: Clk, Reset (async, active-low), LoadClr, Run, MBit (B[0]) in;
//        ClearXA, LoadB, ADD, SUB, SHIFT, Busy, Done out.
// Optional macro SKIP_ZERO_EN: a zero multiplier bit shifts in its EVAL cycle.
module mult_sequencer #(
  parameter int WIDTH    = 8,
  parameter bit RUN_HOLD = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic LoadClr,
  input  logic Run,
  input  logic MBit,
  output logic ClearXA,
  output logic LoadB,
  output logic ADD,
  output logic SUB,
  output logic SHIFT,
  output logic Busy,
  output logic Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ClearXA = 1'b0;
    LoadB   = 1'b0;
    ADD     = 1'b0;
    SUB     = 1'b0;
    SHIFT   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Reset qualifies the user command so outputs stay 0 in reset.
        if (LoadClr && Reset) begin
          ClearXA = 1'b1;
          LoadB   = 1'b1;
        end else if (Run) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ClearXA = 1'b1;
        Busy    = 1'b1;
        cnt_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        Busy = 1'b1;
        if (MBit) begin
          // The final multiplier bit carries negative weight.
          if (cnt_q == LAST) SUB = 1'b1;
          else               ADD = 1'b1;
          state_d = S_SHIFT;
        end else begin
`ifdef SKIP_ZERO_EN
          SHIFT = 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_EVAL;
          end
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        SHIFT = 1'b1;
        Busy  = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_EVAL;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        // Without hold, a still-high Run restarts straight away.
        if (RUN_HOLD)  state_d = S_HOLD;
        else if (Run)  state_d = S_CLEAR;
        else           state_d = S_IDLE;
      end
      S_HOLD: begin
        if (LoadClr && Reset) begin
          ClearXA = 1'b1;
          LoadB   = 1'b1;
        end else if (!Run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
